// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg : shared encodings and stage-record types for the core    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package core_pkg;

  localparam int         REG_ADDR_W      = 5;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fwd_sel : EX-stage operand forwarding select, MEM over WB          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fwd_sel
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteW,
  output logic [1:0]            Fwd
);

  // x0 is hard-wired zero, so a write to it must never be forwarded
  always_comb begin
    Fwd = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
      Fwd = FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      Fwd = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_unit : forwarding selects, stall/flush control and          |
// |               saturating hazard counters for the 5-stage core      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module hazard_unit
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      lw_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  regAddr_t        r_Rs1E, r_Rs2E, r_RdE, r_RdM, r_RdW;
  logic            r_RegWriteE, r_RegWriteM, r_RegWriteW;
  logic [1:0]      r_ResultSrcE;
  logic [CNT_W-1:0] r_lwStallCnt, r_flushCnt;

  logic            w_lwStall;
  logic            w_pcSrc;
  logic            w_flushE;

  // PCSrcE is a raw input, so it is masked to keep all controls low during reset
  assign w_pcSrc   = PCSrcE & ~rst;
  assign w_lwStall = (r_ResultSrcE == RESULT_SRC_LOAD) && r_RegWriteE && (r_RdE != '0)
                     && ((r_RdE == Rs1D) || (r_RdE == Rs2D));
  assign w_flushE  = w_lwStall | w_pcSrc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_Rs1E       <= '0;
      r_Rs2E       <= '0;
      r_RdE        <= '0;
      r_RegWriteE  <= 1'b0;
      r_ResultSrcE <= '0;
      r_RdM        <= '0;
      r_RegWriteM  <= 1'b0;
      r_RdW        <= '0;
      r_RegWriteW  <= 1'b0;
    end else begin
      if (w_flushE) begin
        r_Rs1E       <= '0;
        r_Rs2E       <= '0;
        r_RdE        <= '0;
        r_RegWriteE  <= 1'b0;
        r_ResultSrcE <= '0;
      end else begin
        r_Rs1E       <= Rs1D;
        r_Rs2E       <= Rs2D;
        r_RdE        <= RdD;
        r_RegWriteE  <= RegWriteD;
        r_ResultSrcE <= ResultSrcD;
      end
      r_RdM       <= r_RdE;
      r_RegWriteM <= r_RegWriteE;
      r_RdW       <= r_RdM;
      r_RegWriteW <= r_RegWriteM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lwStallCnt <= '0;
      r_flushCnt   <= '0;
    end else begin
      if (w_lwStall && (r_lwStallCnt != '1)) begin
        r_lwStallCnt <= r_lwStallCnt + C_CNT_ONE;
      end
      if (w_pcSrc && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + C_CNT_ONE;
      end
    end
  end

  fwd_sel u_fwdA (
    .RsE       (r_Rs1E),
    .RdM       (r_RdM),
    .RegWriteM (r_RegWriteM),
    .RdW       (r_RdW),
    .RegWriteW (r_RegWriteW),
    .Fwd       (ForwardAE)
  );

  fwd_sel u_fwdB (
    .RsE       (r_Rs2E),
    .RdM       (r_RdM),
    .RegWriteM (r_RegWriteM),
    .RdW       (r_RdW),
    .RegWriteW (r_RegWriteW),
    .Fwd       (ForwardBE)
  );

  assign StallF       = w_lwStall;
  assign StallD       = w_lwStall;
  assign FlushD       = w_pcSrc;
  assign FlushE       = w_flushE;
  assign lw_stall_cnt = r_lwStallCnt;
  assign flush_cnt    = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_unit : self-checking bench for hazard_unit               |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       PCSrcE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] lw_stall_cnt, flush_cnt;

  logic [1:0]  sFwdA, sFwdB;
  logic        sStallF, sStallD, sFlushD, sFlushE;
  logic [3:0]  sLwCnt, sFlCnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .lw_stall_cnt(lw_stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .ForwardAE(sFwdA), .ForwardBE(sFwdB), .StallF(sStallF), .StallD(sStallD),
    .FlushD(sFlushD), .FlushE(sFlushE), .lw_stall_cnt(sLwCnt), .flush_cnt(sFlCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] rsrc;
    logic       pc;
    logic [7:0] ctl;   // {FwdA, FwdB, StallF, StallD, FlushD, FlushE}
    int         lwc;
    int         flc;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] ctl;
    int         lwc;
    int         flc;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];

  function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int rw,
                              input int rsrc, input int pc, input int fa, input int fb,
                              input int stall, input int fd, input int fe,
                              input int lwc, input int flc);
    vec_t v;
    v.rs1  = 5'(rs1);
    v.rs2  = 5'(rs2);
    v.rd   = 5'(rd);
    v.rw   = 1'(rw);
    v.rsrc = 2'(rsrc);
    v.pc   = 1'(pc);
    v.ctl  = {2'(fa), 2'(fb), 1'(stall), 1'(stall), 1'(fd), 1'(fe)};
    v.lwc  = lwc;
    v.flc  = flc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc, input logic pc);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc; PCSrcE = pc;
  endtask

  function automatic logic [7:0] ctlNow();
    return {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};
  endfunction

  initial begin
    exp_t e;
    //            rs1 rs2 rd rw src pc | fa fb st fd fe | lw fl
    vecs[0]  = mk(1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(5, 3, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[2]  = mk(5, 5, 7, 1, 0, 0,  2, 0, 0, 0, 0,  0, 0);  // x5 at M
    vecs[3]  = mk(6, 0, 0, 1, 0, 0,  2, 2, 0, 0, 0,  0, 0);  // x5 at M and W
    vecs[4]  = mk(0, 7, 9, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[5]  = mk(0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0);  // x7 at W only
    vecs[6]  = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
    vecs[7]  = mk(0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);  // x0 write at M
    vecs[9]  = mk(1, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0);  // lw x7
    vecs[10] = mk(3, 7, 12, 1, 0, 0, 0, 0, 1, 0, 1,  0, 0);  // load-use stall
    vecs[11] = mk(3, 7, 12, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0);  // bubble in E
    vecs[12] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 0);  // load at W
    vecs[13] = mk(1, 2, 3, 1, 0, 1,  0, 0, 0, 1, 1,  1, 0);  // branch taken
    vecs[14] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1);
    vecs[15] = mk(0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0,  1, 1);  // lw x4
    vecs[16] = mk(4, 0, 13, 1, 0, 1, 0, 0, 1, 1, 1,  1, 1);  // stall + flush
    vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2, 2);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    #3;
    check("reset_ctl", 32'(ctlNow()), 32'h0);
    check("reset_cnt", {lw_stall_cnt, flush_cnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].rsrc, vecs[i].pc);
      e.idx = i; e.ctl = vecs[i].ctl; e.lwc = vecs[i].lwc; e.flc = vecs[i].flc;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_ctl", e.idx), 32'(ctlNow()), 32'(e.ctl));
      check($sformatf("vec%0d_lwcnt", e.idx), 32'(lw_stall_cnt), 32'(e.lwc));
      check($sformatf("vec%0d_flcnt", e.idx), 32'(flush_cnt), 32'(e.flc));
      @(posedge clk); #1;
    end

    // self-dependent load repeated: stalls land on every other cycle
    for (int k = 0; k < 40; k++) begin
      drive(7, 0, 7, 1, 1, 0);
      @(negedge clk);
      check($sformatf("sat_stall%0d", k), 32'(StallF), 32'(k % 2));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_lw_small", 32'(sLwCnt), 32'd15);
    check("sat_lw_big", 32'(lw_stall_cnt), 32'd22);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_fl_small", 32'(sFlCnt), 32'd15);
    check("sat_fl_big", 32'(flush_cnt), 32'd22);
    check("sat_lw_small_hold", 32'(sLwCnt), 32'd15);
    @(posedge clk); #1;

    // reset while forwarding is active
    drive(1, 0, 20, 1, 0, 0);
    @(posedge clk); #1;
    drive(20, 20, 21, 1, 0, 0);
    @(posedge clk); #1;
    drive(21, 0, 23, 1, 0, 0);
    @(negedge clk);
    check("pre_rst_fwd", 32'({ForwardAE, ForwardBE}), 32'hA);
    #1;
    rst = 1'b1;
    PCSrcE = 1'b1;
    #1;
    check("async_rst_ctl", 32'(ctlNow()), 32'h0);
    check("async_rst_cnt", {lw_stall_cnt, flush_cnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(21, 21, 22, 1, 0, 0);
    @(negedge clk);
    check("post_rst_d", 32'(ctlNow()), 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
    check("post_rst_cnt", {lw_stall_cnt, flush_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
